// File: rtl/rcs_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and the
// range of operand widths the datapath supports.
package rcs_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/rcs_serial_sub_fs_1bit.sv
// Combinational full subtractor: d = x - y - bin, with borrow-out.
module fs_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/rcs_serial_sub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - borrow_start, LSB first,
// one bit per clock through a single full-subtractor cell.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | one operand bit pair processed per clock
// ST_DONE  | result just published, done high for this cycle
module rcs_serial_sub
  import rcs_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sreg_a;
  logic [WIDTH-1:0] sreg_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d_bit;
  logic             bout;
  logic             last;
  logic             accept;
  logic             busy_nxt;
  logic             done_nxt;

  fs_1bit u_fs (
    .x    (sreg_a[0]),
    .y    (sreg_b[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout)
  );

  assign last    = (cnt == LAST);
  assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_nxt = (res >> 1) | ({{(WIDTH-1){1'b0}}, d_bit} << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == ST_SHIFT);
    done_nxt = (state == ST_SHIFT) && last;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_a <= '0;
      sreg_b <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept) begin
        sreg_a <= a;
        sreg_b <= b;
        br     <= borrow_start;
        cnt    <= '0;
      end else if (state == ST_SHIFT) begin
        sreg_a <= sreg_a >> 1;
        sreg_b <= sreg_b >> 1;
        br     <= bout;
        res    <= res_nxt;
        cnt    <= cnt + CW'(1);
        if (last) begin
          diff   <= res_nxt;
          borrow <= bout;
        end
      end
    end
  end

endmodule
